// File: rtl/ula_mult_div_if.sv
// Request/response bundle for ula_mult_div: operation request in, results and status out.
interface ula_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUCon;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, ALUCon, A, B,
    input  result, hi, lo, zero, busy, done, div_zero
  );

  modport slave (
    input  start, ALUCon, A, B,
    output result, hi, lo, zero, busy, done, div_zero
  );
endinterface

// File: rtl/ula_mult_div.sv
// ALU with single-cycle add/sub/slt and iterative signed mult/div (IDLE -> CALC -> FIX).
// Define ULA_DIV_EN to build the restoring divider; without it ALUCon=011 completes at once with result 0.
module ula_mult_div #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset_n,
  ula_mult_div_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               zero_reg, zero_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [WIDTH-1:0]   mag_b_reg, mag_b_next;
  logic               neg_reg, neg_next;
  logic [CW-1:0]      count_reg, count_next;

  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   slt_res;

  assign mag_a_in = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign mag_b_in = bus.B[WIDTH-1] ? -bus.B : bus.B;
  // acc:q is the running product; each step conditionally adds, then shifts right one bit.
  assign mul_sum  = q_reg[0] ? ({1'b0, acc_reg} + {1'b0, mag_b_reg}) : {1'b0, acc_reg};
  assign prod_fix = neg_reg ? -{acc_reg, q_reg} : {acc_reg, q_reg};
  assign slt_res  = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};

`ifdef ULA_DIV_EN
  logic             op_div_reg, op_div_next;
  logic             neg_rem_reg, neg_rem_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // acc holds the partial remainder, q shifts the dividend out and the quotient in.
  assign div_shift = {acc_reg, q_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_reg};
  assign quot_fix  = neg_reg ? -q_reg : q_reg;
  assign rem_fix   = neg_rem_reg ? -acc_reg : acc_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    result_next   = result_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    zero_next     = zero_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    div_zero_next = div_zero_reg;
    acc_next      = acc_reg;
    q_next        = q_reg;
    mag_b_next    = mag_b_reg;
    neg_next      = neg_reg;
    count_next    = count_reg;
`ifdef ULA_DIV_EN
    op_div_next   = op_div_reg;
    neg_rem_next  = neg_rem_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          div_zero_next = 1'b0;
          done_next     = 1'b1;
          case (bus.ALUCon)
            3'b000: result_next = bus.A + bus.B;
            3'b001: result_next = bus.A - bus.B;
            3'b010: begin
              done_next  = 1'b0;
              busy_next  = 1'b1;
              state_next = CALC;
              acc_next   = '0;
              q_next     = mag_a_in;
              mag_b_next = mag_b_in;
              neg_next   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
              count_next = '0;
`ifdef ULA_DIV_EN
              op_div_next = 1'b0;
`endif
            end
            3'b011: begin
`ifdef ULA_DIV_EN
              if (bus.B == '0) begin
                result_next   = '1;
                hi_next       = bus.A;
                lo_next       = '1;
                div_zero_next = 1'b1;
              end else begin
                done_next    = 1'b0;
                busy_next    = 1'b1;
                state_next   = CALC;
                acc_next     = '0;
                q_next       = mag_a_in;
                mag_b_next   = mag_b_in;
                neg_next     = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                neg_rem_next = bus.A[WIDTH-1];
                op_div_next  = 1'b1;
                count_next   = '0;
              end
`else
              result_next = '0;
`endif
            end
            3'b100:  result_next = slt_res;
            default: result_next = '0;
          endcase
        end
      end

      CALC: begin
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          state_next = FIX;
        end
`ifdef ULA_DIV_EN
        if (op_div_reg) begin
          if (!div_diff[WIDTH]) begin
            acc_next = div_diff[WIDTH-1:0];
            q_next   = {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc_next = div_shift[WIDTH-1:0];
            q_next   = {q_reg[WIDTH-2:0], 1'b0};
          end
        end else
`endif
        begin
          acc_next = mul_sum[WIDTH:1];
          q_next   = {mul_sum[0], q_reg[WIDTH-1:1]};
        end
      end

      FIX: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
`ifdef ULA_DIV_EN
        if (op_div_reg) begin
          hi_next = rem_fix;
          lo_next = quot_fix;
        end else
`endif
        begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
        result_next = lo_next;
      end

      default: state_next = IDLE;
    endcase

    if (done_next) begin
      zero_next = (result_next == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      result_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      zero_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      acc_reg      <= '0;
      q_reg        <= '0;
      mag_b_reg    <= '0;
      neg_reg      <= 1'b0;
      count_reg    <= '0;
`ifdef ULA_DIV_EN
      op_div_reg   <= 1'b0;
      neg_rem_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      result_reg   <= result_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      zero_reg     <= zero_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      div_zero_reg <= div_zero_next;
      acc_reg      <= acc_next;
      q_reg        <= q_next;
      mag_b_reg    <= mag_b_next;
      neg_reg      <= neg_next;
      count_reg    <= count_next;
`ifdef ULA_DIV_EN
      op_div_reg   <= op_div_next;
      neg_rem_reg  <= neg_rem_next;
`endif
    end
  end

  assign bus.result   = result_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.zero     = zero_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
endmodule
